mode_button_ctrl: RTL

- Front-end controller that owns the shared push-buttons and sequences the clock's feature modes.
- Synchronises and debounces four raw buttons, then converts them into single-cycle pulses.
- Drives the 2-bit set_mode bus consumed by the time, alarm and date-setting blocks, and routes button pulses only when a set mode is active.
- Returns to normal time display after an inactivity timeout.

---
 rtl/mode_button_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mode_button_ctrl.sv
// mode_button_ctrl
//
// Front-end controller for the clock's shared push-buttons. It synchronises
// and debounces four raw buttons and turns each debounced press into a
// one-cycle pulse. The mode button steps the set_mode bus through
// RUN(00) -> SET_TIME(01) -> SET_ALARM(10) -> SET_DATE(11) -> RUN. The other
// three pulses are forwarded only while a set mode is active. An idle timer
// forces the clock back to RUN when nobody touches a button for a while.
//
// Optional build macro: AUTOREPEAT_EN
//   When defined, button1 and button2 auto-repeat while held in a set mode.
//   HOLD_CYCLES and REPEAT_CYCLES exist only in that build.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_mode_raw raw mode button (asynchronous, active-high)
//   btn1_raw     raw button 1 (asynchronous, active-high)
//   btn2_raw     raw button 2 (asynchronous, active-high)
//   btn3_raw     raw button 3 (asynchronous, active-high)
//   set_mode     current mode: 00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 SET_DATE
//   button1..3   routed one-cycle button pulses (0 in RUN)
//   mode_entry   one-cycle pulse on every set_mode change
//   timeout      one-cycle pulse when the idle timer forces RUN

module mode_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
`ifdef AUTOREPEAT_EN
    ,
    parameter int HOLD_CYCLES     = 500,
    parameter int REPEAT_CYCLES   = 100
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_raw,
    input  logic       btn1_raw,
    input  logic       btn2_raw,
    input  logic       btn3_raw,
    output logic [1:0] set_mode,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic       mode_entry,
    output logic       timeout
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TM_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_TIME  = 2'b01;
    localparam logic [1:0] MODE_ALARM = 2'b10;
    localparam logic [1:0] MODE_DATE  = 2'b11;

    // Bit 0 is the mode button, bits 1..3 are buttons 1..3.
    logic [3:0]            raw_vec;
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            deb_q, deb_d;
    logic [3:0]            deb_dly_q, deb_dly_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]            pulse_q, pulse_d;
    logic [3:0]            repeat_pulse;

    logic [1:0]            set_mode_q, set_mode_d;
    logic [1:0]            mode_next;
    logic [2:0]            button_q, button_d;
    logic                  mode_entry_q, mode_entry_d;
    logic                  timeout_q, timeout_d;
    logic [TM_W-1:0]       idle_q, idle_d;

    assign raw_vec = {btn3_raw, btn2_raw, btn1_raw, btn_mode_raw};

    // Debounce: the counter only runs while the synchronised level disagrees
    // with the debounced level, so any sample that agrees restarts the count
    // and short glitches never get through.
    always_comb begin
        sync1_d   = raw_vec;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        db_cnt_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        // Only the rising edge of the debounced level produces a pulse.
        pulse_d = (deb_q & ~deb_dly_q) | repeat_pulse;
    end

`ifdef AUTOREPEAT_EN
    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HR_W   = (HR_MAX > 2) ? $clog2(HR_MAX) : 1;

    // Index 0 tracks button1, index 1 tracks button2.
    logic [1:0][HR_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]           repeating_q, repeating_d;
    logic [1:0]           fire;

    // Hold/repeat timing runs off the debounced level: the first extra pulse
    // fires after HOLD_CYCLES of continuous hold, then one per REPEAT_CYCLES.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        repeating_d = repeating_q;
        fire        = '0;
        for (int j = 0; j < 2; j++) begin
            if (!deb_q[j + 1]) begin
                hold_cnt_d[j]  = '0;
                repeating_d[j] = 1'b0;
            end else if (!repeating_q[j]) begin
                if (hold_cnt_q[j] == HR_W'(HOLD_CYCLES - 1)) begin
                    fire[j]        = 1'b1;
                    repeating_d[j] = 1'b1;
                    hold_cnt_d[j]  = '0;
                end else begin
                    hold_cnt_d[j] = hold_cnt_q[j] + HR_W'(1);
                end
            end else begin
                if (hold_cnt_q[j] == HR_W'(REPEAT_CYCLES - 1)) begin
                    fire[j]       = 1'b1;
                    hold_cnt_d[j] = '0;
                end else begin
                    hold_cnt_d[j] = hold_cnt_q[j] + HR_W'(1);
                end
            end
        end
    end

    // Repeats are only meaningful while a set mode is active.
    assign repeat_pulse = {1'b0, fire & {2{set_mode_q != MODE_RUN}}, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= '0;
            repeating_q <= '0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    assign repeat_pulse = '0;
`endif

    // Mode sequencing, button routing and the idle timer. A mode pulse takes
    // priority over both a same-cycle button pulse and a same-cycle timeout.
    always_comb begin
        case (set_mode_q)
            MODE_RUN:   mode_next = MODE_TIME;
            MODE_TIME:  mode_next = MODE_ALARM;
            MODE_ALARM: mode_next = MODE_DATE;
            MODE_DATE:  mode_next = MODE_RUN;
            default:    mode_next = MODE_RUN;
        endcase

        set_mode_d   = set_mode_q;
        mode_entry_d = 1'b0;
        timeout_d    = 1'b0;
        idle_d       = idle_q;

        if (pulse_q[0]) begin
            set_mode_d   = mode_next;
            mode_entry_d = 1'b1;
            idle_d       = '0;
        end else if (set_mode_q != MODE_RUN && idle_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
            set_mode_d   = MODE_RUN;
            mode_entry_d = 1'b1;
            timeout_d    = 1'b1;
            idle_d       = '0;
        end else if (|pulse_q || set_mode_q == MODE_RUN) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + TM_W'(1);
        end

        if (set_mode_q != MODE_RUN && !pulse_q[0]) begin
            button_d = pulse_q[3:1];
        end else begin
            button_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_dly_q    <= '0;
            db_cnt_q     <= '0;
            pulse_q      <= '0;
            set_mode_q   <= MODE_RUN;
            button_q     <= '0;
            mode_entry_q <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_dly_q    <= deb_dly_d;
            db_cnt_q     <= db_cnt_d;
            pulse_q      <= pulse_d;
            set_mode_q   <= set_mode_d;
            button_q     <= button_d;
            mode_entry_q <= mode_entry_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
        end
    end

    assign set_mode   = set_mode_q;
    assign button1    = button_q[0];
    assign button2    = button_q[1];
    assign button3    = button_q[2];
    assign mode_entry = mode_entry_q;
    assign timeout    = timeout_q;

endmodule
